// File: rtl/router_pkt_reg.sv
// Router datapath register stage: header latch, payload/hold byte steering to dout,
// running parity accumulation and parity-error / low-valid reporting to the control FSM.
module router_pkt_reg #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 2
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  pkt_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  fifo_full,
   input  logic                  detect_add,
   input  logic                  lfd_state,
   input  logic                  ld_state,
   input  logic                  laf_state,
   input  logic                  full_state,
   input  logic                  rst_int_reg,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  parity_done,
   output logic                  low_packet_valid,
   output logic                  err
);

   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [DATA_WIDTH-1:0] header_q, header_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_tag_q, hold_tag_d;
   logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
   logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
   logic                  parity_done_q, parity_done_d;
   logic                  low_pkt_valid_q, low_pkt_valid_d;
   logic                  err_q, err_d;

   always_comb begin
      dout_d          = dout_q;
      header_d        = header_q;
      hold_d          = hold_q;
      hold_tag_d      = hold_tag_q;
      int_parity_d    = int_parity_q;
      pkt_parity_d    = pkt_parity_q;
      parity_done_d   = parity_done_q;
      low_pkt_valid_d = low_pkt_valid_q;
      err_d           = err_q;

      // full_state needs no branch: everything holds by default
      if (detect_add) begin
         if (pkt_valid && (data_in[ADDR_BITS-1:0] != '1)) begin
            header_d = data_in;
         end
         int_parity_d  = '0;
         parity_done_d = 1'b0;
      end else if (lfd_state) begin
         dout_d       = header_q;
         int_parity_d = int_parity_q ^ header_q;
      end else if (ld_state) begin
         if (fifo_full) begin
            hold_d     = data_in;
            hold_tag_d = pkt_valid;
         end else begin
            dout_d = data_in;
            if (pkt_valid) begin
               int_parity_d = int_parity_q ^ data_in;
            end else begin
               pkt_parity_d  = data_in;
               parity_done_d = 1'b1;
            end
         end
      end else if (laf_state) begin
         dout_d = hold_q;
         if (hold_tag_q) begin
            int_parity_d = int_parity_q ^ hold_q;
         end else if (!parity_done_q) begin
            pkt_parity_d  = hold_q;
            parity_done_d = 1'b1;
         end
      end

      if (ld_state && !pkt_valid) begin
         low_pkt_valid_d = 1'b1;
      end else if (rst_int_reg) begin
         low_pkt_valid_d = 1'b0;
      end

      // err is cleared when a new packet starts and otherwise only re-evaluated in the check cycle
      if (!detect_add && lfd_state) begin
         err_d = 1'b0;
      end else if (rst_int_reg && parity_done_q) begin
         err_d = (int_parity_q != pkt_parity_q);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         dout_q          <= '0;
         header_q        <= '0;
         hold_q          <= '0;
         hold_tag_q      <= 1'b0;
         int_parity_q    <= '0;
         pkt_parity_q    <= '0;
         parity_done_q   <= 1'b0;
         low_pkt_valid_q <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         dout_q          <= dout_d;
         header_q        <= header_d;
         hold_q          <= hold_d;
         hold_tag_q      <= hold_tag_d;
         int_parity_q    <= int_parity_d;
         pkt_parity_q    <= pkt_parity_d;
         parity_done_q   <= parity_done_d;
         low_pkt_valid_q <= low_pkt_valid_d;
         err_q           <= err_d;
      end
   end

   assign dout             = dout_q;
   assign parity_done      = parity_done_q;
   assign low_packet_valid = low_pkt_valid_q;
   assign err              = err_q;

endmodule
